mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory line port between the instruction-cache fill path and the data-cache fill/writeback path.
- Accepts one line request at a time, forwards it to memory, and routes the memory response back to the owner.
- Sits between the icache/dcache miss logic and the memory model. The memory model applies MEM_REQ_DELAY and MEM_RESP_DELAY itself.

Parameters:
- ADDR_W, ADDRESS_WIDTH (32): request address width.
- LINE_W, CACHE_LINE_WIDTH (128): line data width.
- OFFSET_BITS, $clog2(LINE_W/BYTE_WIDTH) (4): low address bits forced to zero on the memory port.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ic_req_valid  in  1  icache line-fill request.
- ic_req_ready  out  1  icache request accepted this cycle.
- ic_req_addr  in  ADDR_W  icache fill address.
- ic_resp_valid  out  1  icache fill data valid, one-cycle pulse.
- ic_resp_data  out  LINE_W  icache fill line.
- dc_req_valid  in  1  dcache request.
- dc_req_ready  out  1  dcache request accepted this cycle.
- dc_req_addr  in  ADDR_W  dcache address.
- dc_req_store  in  1  1 = line writeback, 0 = fill.
- dc_req_data  in  LINE_W  writeback line.
- dc_resp_valid  out  1  dcache fill data / store ack, one-cycle pulse.
- dc_resp_data  out  LINE_W  dcache fill line.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  line-aligned address.
- mem_req_store  out  1  write flag.
- mem_req_data  out  LINE_W  write line.
- mem_resp_valid  in  1  memory response, one-cycle pulse.
- mem_resp_data  in  LINE_W  response line.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT.
- Reset (async, rst_n=0) values:
  - state=IDLE, owner=DCACHE, rr_last=ICACHE.
  - Latched addr/data/store = 0.
  - All *_ready, *_valid outputs = 0; resp data outputs = 0 when not valid.
- Reset mid-transaction drops the transaction silently. A pending mem_resp_valid after reset is ignored because state is IDLE.
- IDLE:
  - Winner chosen combinationally from the valid requests (see Optional Feature).
  - Winner's *_req_ready = 1 in the same cycle; the loser's ready = 0.
  - On that edge: latch owner, addr with low OFFSET_BITS cleared, store flag (0 for icache) and data; go to ISSUE.
  - *_req_ready is never asserted outside IDLE.
- ISSUE:
  - mem_req_valid = 1 with the latched fields, which stay stable.
  - When mem_req_ready = 1, go to WAIT.
  - mem_req_valid must not drop before acceptance.
- WAIT:
  - When mem_resp_valid = 1, drive owner's *_resp_valid = 1 and *_resp_data = mem_resp_data combinationally in the same cycle; go to IDLE.
  - Store transactions also complete on mem_resp_valid (ack; data ignored by dcache).
- mem_resp_valid in IDLE or ISSUE is ignored.
- Throughput: at most one transaction outstanding. Minimum 3 cycles from acceptance to next acceptance (accept, issue, response).
- Requester contract: a requester keeps *_req_valid and its fields stable until ready. The arbiter never accepts both requesters in one cycle.
- Simultaneous mem_resp_valid and new requests: the response completes this cycle. The new request is accepted no earlier than the next cycle (IDLE).

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On a tie the requester not granted last (rr_last) wins.
  - rr_last updates on each acceptance.
- Undefined: fixed priority, dcache wins all ties, and rr_last is not implemented.
- In both modes a single requester is granted immediately.

Decomposition:
- brisc_pkg gains:
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT}.
  - typedef enum logic mem_req_id_e {REQ_ICACHE=0, REQ_DCACHE=1}.
- Widths use the existing ADDRESS_WIDTH / CACHE_LINE_WIDTH / BYTE_WIDTH.
- No sub-module. Grant logic is a small always_comb block inside mem_arbiter.

Test Plan:
- Reset: hold rst_n=0 with ic/dc_req_valid=1 → all ready/valid outputs 0. Release → dc_req_ready=1 in the first IDLE cycle (rr_last=ICACHE or fixed priority).
- Single icache fill, addr 0x0000100C:
  - ic_req_ready pulses, then mem_req_addr=0x00001000, mem_req_store=0.
  - Memory responds after 5+5 cycles with 0xDEADBEEF_..._0001 → ic_resp_valid pulses one cycle with that line; dc_resp_valid stays 0.
- Dcache writeback, addr 0x4010, data 0xA5...A5:
  - mem_req_store=1 and mem_req_data equals the input.
  - mem_req_valid holds while mem_req_ready=0 for 3 cycles, fields stable.
  - Ack → dc_resp_valid one pulse.
- Simultaneous requests, back-to-back:
  - With MEM_ARB_RR_EN: order dcache, icache, dcache.
  - Without: dcache always served first while dc_req_valid is held.
- Spurious mem_resp_valid in IDLE and in ISSUE → no *_resp_valid, state unchanged.
- Reset asserted in WAIT: state returns to IDLE. The late mem_resp_valid produces no response, and a new request is accepted normally.

Source files
------------

// File: rtl/brisc_pkg.sv
// brisc_pkg: shared widths and enumerations for the memory-side blocks.
// The memory arbiter uses arb_state_e for its FSM and mem_req_id_e to tag
// which cache owns the transaction in flight.
package brisc_pkg;

    localparam int ADDRESS_WIDTH    = 32;
    localparam int CACHE_LINE_WIDTH = 128;
    localparam int BYTE_WIDTH       = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_ICACHE = 1'b0,
        REQ_DCACHE = 1'b1
    } mem_req_id_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory line port between the icache
// fill path and the dcache fill/writeback path. One transaction at a time:
// accept (IDLE) -> present to memory (ISSUE) -> wait for response (WAIT).
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking; otherwise
// the dcache wins every tie.
module mem_arbiter
    import brisc_pkg::*;
#(
    parameter int ADDR_W      = ADDRESS_WIDTH,
    parameter int LINE_W      = CACHE_LINE_WIDTH,
    parameter int OFFSET_BITS = $clog2(LINE_W / BYTE_WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    output logic [LINE_W-1:0] ic_resp_data,

    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_store,
    input  logic [LINE_W-1:0] dc_req_data,
    output logic              dc_resp_valid,
    output logic [LINE_W-1:0] dc_resp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_store,
    output logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_data
);

    arb_state_e        state_reg, state_next;
    mem_req_id_e       owner_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LINE_W-1:0] data_reg;
    logic              store_reg;

`ifdef MEM_ARB_RR_EN
    mem_req_id_e       rr_last_reg;
`endif

    logic              grant_valid;
    mem_req_id_e       grant_id;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] aligned_addr;
    logic [LINE_W-1:0] sel_data;
    logic              sel_store;

    // Grant selection: a lone requester always wins; ties go by the build mode
    always_comb begin
        grant_valid = ic_req_valid | dc_req_valid;
        grant_id    = REQ_DCACHE;
        if (ic_req_valid && !dc_req_valid) begin
            grant_id = REQ_ICACHE;
        end
`ifdef MEM_ARB_RR_EN
        else if (ic_req_valid && dc_req_valid && (rr_last_reg == REQ_DCACHE)) begin
            grant_id = REQ_ICACHE;
        end
`endif
    end

    assign accept = (state_reg == ARB_IDLE) && grant_valid;

    // Mux the winner's fields; the icache never writes, so its store/data are zero
    always_comb begin
        sel_addr  = ic_req_addr;
        sel_data  = '0;
        sel_store = 1'b0;
        if (grant_id == REQ_DCACHE) begin
            sel_addr  = dc_req_addr;
            sel_data  = dc_req_data;
            sel_store = dc_req_store;
        end
    end

    // Memory sees whole lines only: clear the byte-offset bits
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_align
        if (gi < OFFSET_BITS) begin : g_zero
            assign aligned_addr[gi] = 1'b0;
        end else begin : g_keep
            assign aligned_addr[gi] = sel_addr[gi];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; stray memory responses outside WAIT are ignored
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ARB_IDLE:  if (grant_valid)    state_next = ARB_ISSUE;
            ARB_ISSUE: if (mem_req_ready)  state_next = ARB_WAIT;
            ARB_WAIT:  if (mem_resp_valid) state_next = ARB_IDLE;
            default:                       state_next = ARB_IDLE;
        endcase
    end

    // Capture the accepted request; fields stay frozen until the next acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg <= REQ_DCACHE;
            addr_reg  <= '0;
            data_reg  <= '0;
            store_reg <= 1'b0;
        end else if (accept) begin
            owner_reg <= grant_id;
            addr_reg  <= aligned_addr;
            data_reg  <= sel_data;
            store_reg <= sel_store;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember the last winner so the other side wins the next tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_reg <= REQ_ICACHE;
        end else if (accept) begin
            rr_last_reg <= grant_id;
        end
    end
`endif

    // Outputs: ready only in IDLE (and never while reset is held),
    // responses routed straight through to the owner in WAIT
    always_comb begin
        ic_req_ready  = rst_n && accept && (grant_id == REQ_ICACHE);
        dc_req_ready  = rst_n && accept && (grant_id == REQ_DCACHE);
        mem_req_valid = (state_reg == ARB_ISSUE);
        mem_req_addr  = addr_reg;
        mem_req_store = store_reg;
        mem_req_data  = data_reg;
        ic_resp_valid = (state_reg == ARB_WAIT) && mem_resp_valid && (owner_reg == REQ_ICACHE);
        dc_resp_valid = (state_reg == ARB_WAIT) && mem_resp_valid && (owner_reg == REQ_DCACHE);
        ic_resp_data  = ic_resp_valid ? mem_resp_data : '0;
        dc_resp_data  = dc_resp_valid ? mem_resp_data : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. The bench plays both
// caches and the memory model. A vector table drives complete single-requester
// transactions; hand-written sequences cover reset, ties, stray responses and
// reset during WAIT.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [31:0]  ic_req_addr;
    logic [127:0] ic_resp_data;
    logic         dc_req_valid, dc_req_ready, dc_req_store, dc_resp_valid;
    logic [31:0]  dc_req_addr;
    logic [127:0] dc_req_data, dc_resp_data;
    logic         mem_req_valid, mem_req_ready, mem_req_store, mem_resp_valid;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data, mem_resp_data;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ic_req_valid   (ic_req_valid),
        .ic_req_ready   (ic_req_ready),
        .ic_req_addr    (ic_req_addr),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_data   (ic_resp_data),
        .dc_req_valid   (dc_req_valid),
        .dc_req_ready   (dc_req_ready),
        .dc_req_addr    (dc_req_addr),
        .dc_req_store   (dc_req_store),
        .dc_req_data    (dc_req_data),
        .dc_resp_valid  (dc_resp_valid),
        .dc_resp_data   (dc_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_store  (mem_req_store),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    typedef struct {
        logic         is_dc;
        logic         store;
        logic [31:0]  addr;
        logic [127:0] wdata;
        int           stall;     // cycles mem_req_ready held low in ISSUE
        int           wait_cyc;  // idle cycles in WAIT before the response
        logic [127:0] rdata;
        logic [31:0]  exp_addr;  // line-aligned address expected at memory
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from a single requester, starting in IDLE
    task automatic run_txn(input vec_t v, input int idx);
        $display("[TB] txn %0d: %s addr=%h store=%0d stall=%0d wait=%0d",
                 idx, v.is_dc ? "dcache" : "icache", v.addr, v.store, v.stall, v.wait_cyc);
        ic_req_valid   = !v.is_dc;
        dc_req_valid   = v.is_dc;
        ic_req_addr    = v.addr;
        dc_req_addr    = v.addr;
        dc_req_store   = v.store;
        dc_req_data    = v.wdata;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        chk("accept_ic_ready", ic_req_ready, !v.is_dc);
        chk("accept_dc_ready", dc_req_ready, v.is_dc);
        chk("accept_mem_valid", mem_req_valid, 1'b0);
        step();
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        for (int c = 0; c <= v.stall; c++) begin
            mem_req_ready = (c == v.stall);
            #1;
            chk("issue_mem_valid", mem_req_valid, 1'b1);
            chk("issue_addr", mem_req_addr, v.exp_addr);
            chk("issue_store", mem_req_store, v.store);
            if (v.store) chk("issue_data", mem_req_data, v.wdata);
            chk("issue_no_ready", {ic_req_ready, dc_req_ready}, 2'b00);
            step();
        end
        mem_req_ready = 1'b0;
        for (int c = 0; c < v.wait_cyc; c++) begin
            #1;
            chk("wait_no_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
            chk("wait_mem_valid", mem_req_valid, 1'b0);
            step();
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = v.rdata;
        #1;
        chk("resp_ic_valid", ic_resp_valid, !v.is_dc);
        chk("resp_dc_valid", dc_resp_valid, v.is_dc);
        chk("resp_owner_data", v.is_dc ? dc_resp_data : ic_resp_data, v.rdata);
        chk("resp_other_data", v.is_dc ? ic_resp_data : dc_resp_data, 128'h0);
        step();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        #1;
        chk("resp_pulse_end", {ic_resp_valid, dc_resp_valid}, 2'b00);
    endtask

    logic exp_dc [3];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_100C, 128'h0, 5, 5,
                    128'hDEADBEEF_00000000_00000000_00000001, 32'h0000_1000};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_4010, {16{8'hA5}}, 3, 2,
                    128'h0, 32'h0000_4010};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_ABCF, 128'h0, 0, 0,
                    128'h01234567_89ABCDEF_FEDCBA98_76543210, 32'h0000_ABC0};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 128'h0, 1, 1,
                    128'hCAFEF00D_11112222_33334444_55556666, 32'hFFFF_FFF0};

        // Reset held with both requests pending and a stray response
        rst_n          = 1'b0;
        ic_req_valid   = 1'b1;
        dc_req_valid   = 1'b1;
        ic_req_addr    = 32'h0000_2004;
        dc_req_addr    = 32'h0000_3018;
        dc_req_store   = 1'b0;
        dc_req_data    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = '1;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset held");
        chk("rst_ready", {ic_req_ready, dc_req_ready}, 2'b00);
        chk("rst_mem_valid", mem_req_valid, 1'b0);
        chk("rst_resp_valid", {ic_resp_valid, dc_resp_valid}, 2'b00);
        chk("rst_resp_data", ic_resp_data | dc_resp_data, 128'h0);
        chk("rst_mem_addr", mem_req_addr, 32'h0);
        chk("rst_mem_store", mem_req_store, 1'b0);

        // Release with both requests held: back-to-back tie resolution
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        rst_n          = 1'b1;
`ifdef MEM_ARB_RR_EN
        exp_dc = '{1'b1, 1'b0, 1'b1};
`else
        exp_dc = '{1'b1, 1'b1, 1'b1};
`endif
        for (int g = 0; g < 3; g++) begin
            #1;
            $display("[TB] tie grant %0d: expect %s", g, exp_dc[g] ? "dcache" : "icache");
            chk("tie_ic_ready", ic_req_ready, !exp_dc[g]);
            chk("tie_dc_ready", dc_req_ready, exp_dc[g]);
            step();
            mem_req_ready = 1'b1;
            #1;
            chk("tie_issue_valid", mem_req_valid, 1'b1);
            chk("tie_issue_addr", mem_req_addr, exp_dc[g] ? 32'h0000_3010 : 32'h0000_2000);
            chk("tie_issue_no_ready", {ic_req_ready, dc_req_ready}, 2'b00);
            step();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_data  = 128'h100 + 128'(g);
            #1;
            chk("tie_resp_ic", ic_resp_valid, !exp_dc[g]);
            chk("tie_resp_dc", dc_resp_valid, exp_dc[g]);
            chk("tie_resp_no_ready", {ic_req_ready, dc_req_ready}, 2'b00);
            step();
            mem_resp_valid = 1'b0;
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;

        // Stray response in IDLE, then in ISSUE
        mem_resp_valid = 1'b1;
        mem_resp_data  = '1;
        #1;
        $display("[TB] stray response in IDLE");
        chk("stray_idle_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
        chk("stray_idle_mem_valid", mem_req_valid, 1'b0);
        step();
        mem_resp_valid = 1'b0;
        ic_req_valid   = 1'b1;
        ic_req_addr    = 32'h0000_5555;
        #1;
        chk("stray_idle_still_idle", ic_req_ready, 1'b1);
        step();
        ic_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        $display("[TB] stray response in ISSUE");
        chk("stray_issue_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
        chk("stray_issue_mem_valid", mem_req_valid, 1'b1);
        step();
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        #1;
        chk("stray_issue_still_issue", mem_req_valid, 1'b1);
        chk("stray_issue_addr", mem_req_addr, 32'h0000_5550);
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'h55;
        #1;
        chk("stray_final_resp", ic_resp_valid, 1'b1);
        chk("stray_final_data", ic_resp_data, 128'h55);
        step();
        mem_resp_valid = 1'b0;

        // Table of single-requester transactions
        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i], i);
        end

        // Reset asserted while waiting for the response
        dc_req_valid = 1'b1;
        dc_req_addr  = 32'h0000_7004;
        dc_req_store = 1'b0;
        #1;
        $display("[TB] reset during WAIT");
        chk("rstwait_accept", dc_req_ready, 1'b1);
        step();
        dc_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstwait_mem_valid", mem_req_valid, 1'b0);
        chk("rstwait_mem_addr", mem_req_addr, 32'h0);
        step();
        rst_n          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 128'h77;
        #1;
        chk("rstwait_late_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
        step();
        mem_resp_valid = 1'b0;
        run_txn(vecs[2], 4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
